// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder/subtractor between NUM_REQ requesters.
// One grant per cycle, result registered with carry and source id, one-cycle latency.
module add_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_op,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         res_sum,
  output logic                     res_carry,
  output logic [IDW-1:0]           res_id,
  input  logic                     res_ready
);

  logic [IDW-1:0]   ptr_r;
  logic             res_valid_r;
  logic [WIDTH-1:0] res_sum_r;
  logic             res_carry_r;
  logic [IDW-1:0]   res_id_r;

  logic             slot_free_s;
  logic             found_s;
  logic [IDW-1:0]   winner_s;
  logic             accept_s;
  logic [IDW-1:0]   ptr_next_s;
  logic [WIDTH-1:0] a_sel_s;
  logic [WIDTH-1:0] b_sel_s;
  logic             op_sel_s;
  logic [WIDTH:0]   dp_s;

  assign slot_free_s = !res_valid_r || res_ready;
  assign accept_s    = found_s && slot_free_s && !rst;

  // Rotating priority search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [IDW:0] idx_ext;
    logic [IDW:0] idx_wrap;
    found_s  = 1'b0;
    winner_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_ext  = {1'b0, ptr_r} + (IDW+1)'(k);
      idx_wrap = (idx_ext >= (IDW+1)'(NUM_REQ)) ? idx_ext - (IDW+1)'(NUM_REQ) : idx_ext;
      if (!found_s && req_valid[idx_wrap[IDW-1:0]]) begin
        found_s  = 1'b1;
        winner_s = idx_wrap[IDW-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept_s) begin
      req_ready[winner_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  always_comb begin
    a_sel_s  = '0;
    b_sel_s  = '0;
    op_sel_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner_s == IDW'(i)) begin
        a_sel_s  = req_a[i*WIDTH +: WIDTH];
        b_sel_s  = req_b[i*WIDTH +: WIDTH];
        op_sel_s = req_op[i];
      end else begin
        op_sel_s = op_sel_s;
      end
    end
  end

  // Single shared adder: subtraction is A + ~B + 1, carry doubles as no-borrow.
  assign dp_s = {1'b0, a_sel_s} + {1'b0, (op_sel_s ? ~b_sel_s : b_sel_s)} + {{WIDTH{1'b0}}, op_sel_s};

  assign ptr_next_s = (winner_s == IDW'(NUM_REQ-1)) ? '0 : winner_s + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r       <= '0;
      res_valid_r <= 1'b0;
      res_sum_r   <= '0;
      res_carry_r <= 1'b0;
      res_id_r    <= '0;
    end else if (accept_s) begin
      ptr_r       <= ptr_next_s;
      res_valid_r <= 1'b1;
      res_sum_r   <= dp_s[WIDTH-1:0];
      res_carry_r <= dp_s[WIDTH];
      res_id_r    <= winner_s;
    end else if (res_ready) begin
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= res_valid_r;
    end
  end

  assign res_valid = res_valid_r;
  assign res_sum   = res_sum_r;
  assign res_carry = res_carry_r;
  assign res_id    = res_id_r;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter: reset, add, subtract, streaming,
// backpressure and mid-stream reset, with hand-computed expectations.
module tb_add_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_op;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [7:0]  res_sum;
  logic        res_carry;
  logic [1:0]  res_id;
  logic        res_ready;

  int vectors;
  int miscompares;

  add_share_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_ready(req_ready),
    .res_valid(res_valid), .res_sum(res_sum), .res_carry(res_carry), .res_id(res_id),
    .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic op);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_op[i]       = op;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; res_ready = 1'b1;
    req_a = 32'h0; req_b = 32'h0; req_op = 4'b0000;
    tick(); tick();
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    vectors++; if (res_sum !== 8'h00) begin miscompares++; $display("FAIL reset_res_sum: got %h expected 00", res_sum); end
    vectors++; if (res_carry !== 1'b0) begin miscompares++; $display("FAIL reset_res_carry: got %b expected 0", res_carry); end
    vectors++; if (res_id !== 2'd0) begin miscompares++; $display("FAIL reset_res_id: got %0d expected 0", res_id); end
    rst = 1'b0; #1;
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL post_reset_grant: got %b expected 0001", req_ready); end
    req_valid = 4'b0000; #1;
  endtask

  task automatic test_single_add();
    set_req(2, 8'hF0, 8'h20, 1'b0);
    req_valid = 4'b0100; #1;
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL add_grant: got %b expected 0100", req_ready); end
    tick();
    req_valid = 4'b0000; #1;
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid: got %b expected 1", res_valid); end
    vectors++; if (res_sum !== 8'h10) begin miscompares++; $display("FAIL add_sum: got %h expected 10", res_sum); end
    vectors++; if (res_carry !== 1'b1) begin miscompares++; $display("FAIL add_carry: got %b expected 1", res_carry); end
    vectors++; if (res_id !== 2'd2) begin miscompares++; $display("FAIL add_id: got %0d expected 2", res_id); end
    tick();
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL add_consumed: got %b expected 0", res_valid); end
  endtask

  task automatic test_sub();
    set_req(1, 8'h05, 8'h07, 1'b1);
    req_valid = 4'b0010; #1;
    vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL sub_grant: got %b expected 0010", req_ready); end
    tick();
    vectors++; if (res_sum !== 8'hFE) begin miscompares++; $display("FAIL sub_borrow_sum: got %h expected fe", res_sum); end
    vectors++; if (res_carry !== 1'b0) begin miscompares++; $display("FAIL sub_borrow_carry: got %b expected 0", res_carry); end
    vectors++; if (res_id !== 2'd1) begin miscompares++; $display("FAIL sub_id: got %0d expected 1", res_id); end
    set_req(1, 8'h07, 8'h05, 1'b1); #1;
    vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL sub2_grant: got %b expected 0010", req_ready); end
    tick();
    req_valid = 4'b0000; #1;
    vectors++; if (res_sum !== 8'h02) begin miscompares++; $display("FAIL sub_noborrow_sum: got %h expected 02", res_sum); end
    vectors++; if (res_carry !== 1'b1) begin miscompares++; $display("FAIL sub_noborrow_carry: got %b expected 1", res_carry); end
  endtask

  // Entered with res_valid=1 and ptr=2 left by test_sub.
  task automatic test_reset_mid();
    vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid: got %b expected 1", res_valid); end
    rst = 1'b1; req_valid = 4'b1111; #1;
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); end
    tick();
    rst = 1'b0; #1;
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b expected 0", res_valid); end
    vectors++; if (res_sum !== 8'h00) begin miscompares++; $display("FAIL mid_rst_sum: got %h expected 00", res_sum); end
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL mid_rst_grant: got %b expected 0001", req_ready); end
  endtask

  task automatic test_stream();
    logic [1:0] exp_g [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [7:0] exp_s [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [3:0] onehot;
    set_req(0, 8'h10, 8'h01, 1'b0);
    set_req(1, 8'h20, 8'h02, 1'b0);
    set_req(2, 8'h30, 8'h03, 1'b0);
    set_req(3, 8'h40, 8'h04, 1'b0);
    req_valid = 4'b1111; res_ready = 1'b1; #1;
    for (int k = 0; k < 6; k++) begin
      onehot = 4'b0001 << exp_g[k];
      vectors++; if (req_ready !== onehot) begin miscompares++; $display("FAIL stream_grant%0d: got %b expected %b", k, req_ready, onehot); end
      tick();
      vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid%0d: got %b expected 1", k, res_valid); end
      vectors++; if (res_id !== exp_g[k]) begin miscompares++; $display("FAIL stream_id%0d: got %0d expected %0d", k, res_id, exp_g[k]); end
      vectors++; if (res_sum !== exp_s[exp_g[k]]) begin miscompares++; $display("FAIL stream_sum%0d: got %h expected %h", k, res_sum, exp_s[exp_g[k]]); end
    end
  endtask

  // Continues the stream: last grantee was 1, so 2 is next after release.
  task automatic test_backpressure();
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_ready%0d: got %b expected 0000", k, req_ready); end
      tick();
      vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid%0d: got %b expected 1", k, res_valid); end
      vectors++; if (res_id !== 2'd1) begin miscompares++; $display("FAIL bp_id%0d: got %0d expected 1", k, res_id); end
      vectors++; if (res_sum !== 8'h22) begin miscompares++; $display("FAIL bp_sum%0d: got %h expected 22", k, res_sum); end
    end
    res_ready = 1'b1; #1;
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL bp_release_grant: got %b expected 0100", req_ready); end
    tick();
    req_valid = 4'b0000; #1;
    vectors++; if (res_id !== 2'd2) begin miscompares++; $display("FAIL bp_release_id: got %0d expected 2", res_id); end
    vectors++; if (res_sum !== 8'h33) begin miscompares++; $display("FAIL bp_release_sum: got %h expected 33", res_sum); end
    tick();
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid: got %b expected 0", res_valid); end
    vectors++; if (res_sum !== 8'h33) begin miscompares++; $display("FAIL drain_hold_sum: got %h expected 33", res_sum); end
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL idle_ready: got %b expected 0000", req_ready); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_add();
    test_sub();
    test_reset_mid();
    test_stream();
    test_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/add_share_arbiter.md
# add_share_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit adder/subtractor between NUM_REQ requesters. Each requester presents an operand pair and an op bit with a valid/ready handshake. The block grants at most one request per cycle, computes the result on the single shared datapath, and registers it with carry and source ID. It sits between the I/O-facing requester logic and downstream result consumers.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width
- IDW, $clog2(NUM_REQ), derived width of res_id
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset: one clock, synchronous, active-high
- req_valid  in  NUM_REQ  request pending, bit i = requester i
- req_a  in  NUM_REQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- req_op  in  NUM_REQ  per requester: 0 = A+B, 1 = A−B
- req_ready  out  NUM_REQ  one-hot (or zero) accept strobe; handshake completes on valid&ready
- res_valid  out  1  result register holds an unconsumed result
- res_sum  out  WIDTH  result low WIDTH bits
- res_carry  out  1  add: carry-out; sub: 1 = no borrow (A ≥ B unsigned)
- res_id  out  IDW  index of requester that produced the result
- res_ready  in  1  consumer accepts result when res_valid&res_ready

## Operation
- Registered state: RR pointer ptr (IDW bits), result register {res_valid, res_sum, res_carry, res_id}.
- Slot free: slot_free = !res_valid || res_ready.
- Grant: when slot_free, the winner is the first i with req_valid[i]=1, scanning ptr, ptr+1, …, wrapping modulo NUM_REQ. req_ready[winner]=1 and all other bits are 0. When !slot_free or no valid request, req_ready is all zero.
- Accept (valid&ready on winner w):
  - res_sum/res_carry are loaded from the shared datapath.
  - res_id is set to w and res_valid to 1.
  - ptr is set to (w+1) mod NUM_REQ.
- Datapath: one WIDTH+1-bit adder computing {carry,sum} = A + (op ? ~B : B) + op, with operands muxed by the grant. No second adder is instantiated.
- Consume without accept: res_valid goes to 0. Result fields hold their last values.
- Simultaneous consume and accept in the same cycle: the new result replaces the old one and res_valid stays 1. Full throughput is one result per cycle.
- Requester rules: once req_valid[i] is asserted, the requester holds req_a/req_b/req_op stable until accepted. Deasserting before acceptance is allowed (the request is withdrawn) and is never granted.
- ptr only advances on an accept. Idle cycles and backpressure leave ptr unchanged.
- Fairness: any continuously valid requester is granted within NUM_REQ accepts.
- Reset (in any cycle, including mid-stream):
  - res_valid=0, res_sum=0, res_carry=0, res_id=0, ptr=0.
  - req_ready is forced to all zero while rst=1.
  - An in-flight unconsumed result is discarded.

## Timing
- Accept-to-result latency: 1 cycle. Accept in cycle N gives res_valid=1 with the result in cycle N+1.
- req_ready is combinational from req_valid, ptr, res_valid, res_ready and rst. This includes a combinational path res_ready → req_ready.
- res_* outputs are registered, with no combinational path from the req_* inputs.
- Backpressure: while res_valid=1 and res_ready=0, the outputs are held stable and req_ready=0.
- Wrap-around: ptr at NUM_REQ−1 with a grant to NUM_REQ−1 sets ptr=0.
- Reset values of all outputs: res_valid=0, res_sum=0, res_carry=0, res_id=0, req_ready=0.

## Test plan
- Reset: hold rst=1 with req_valid=4'b1111 and res_ready=1 → req_ready=0 and all res_* = 0. On the first cycle after reset, req_ready=4'b0001.
- Single add: req_valid=4'b0100, a2=0xF0, b2=0x20, op2=0 → req_ready=4'b0100. Next cycle: res_valid=1, res_sum=0x10, res_carry=1, res_id=2.
- Subtract: requester 1, a=0x05, b=0x07, op=1 → res_sum=0xFE, res_carry=0. Then a=0x07, b=0x05 → res_sum=0x02, res_carry=1.
- Round-robin streaming: req_valid=4'b1111 held, res_ready=1 → grants 0,1,2,3,0,1 on consecutive cycles, res_id follows one cycle later, and res_valid stays 1 throughout.
- Backpressure and priority: during a stream, drop res_ready for 3 cycles → req_ready=0 and res_* frozen for those cycles. On release, the held result is consumed and the next grant goes to the requester after the last grantee, in the same cycle.
- Reset mid-stream: assert rst for one cycle while res_valid=1 and ptr=2 → res_valid=0 next cycle. With all requests valid, the next grant is to requester 0.
